// File: rtl/multitap_pkg.sv
// Shared types and encodings for the Team Player-style multitap serializer.
package multitap_pkg;

  typedef enum logic [1:0] {
    PT_3BTN = 2'b00,
    PT_6BTN = 2'b01,
    PT_NONE = 2'b10
  } pad_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEQ,
    ST_ABORT
  } state_t;

  // Bit positions inside one pad's 12-bit BUTTONS slice.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  localparam logic [3:0] HDR_NIB0  = 4'h3;
  localparam logic [3:0] HDR_NIB1  = 4'hF;
  localparam logic [3:0] HDR_NIB2  = 4'h0;
  localparam logic [3:0] HDR_NIB3  = 4'h0;
  localparam logic [3:0] IDLE_NIB  = 4'h3;
  localparam logic [3:0] EMPTY_NIB = 4'hF;

  // Both 1x codes mean "no pad attached".
  function automatic pad_type_t decode_type(input logic [1:0] code);
    if (code[1])      return PT_NONE;
    else if (code[0]) return PT_6BTN;
    else              return PT_3BTN;
  endfunction

  function automatic logic [3:0] type_nibble(input pad_type_t t);
    case (t)
      PT_3BTN: return 4'h0;
      PT_6BTN: return 4'h1;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [1:0] pad_len(input pad_type_t t);
    case (t)
      PT_3BTN: return 2'd2;
      PT_6BTN: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/multitap_tp_n_nibble_mux.sv
// Combinational map from read index to port nibble, using the frozen snapshot.
module tp_nibble_mux
  import multitap_pkg::*;
#(
  parameter int PADS = 4,
  parameter int IW   = 5
) (
  input  logic [IW-1:0]            idx,
  input  logic [PADS*12-1:0]       buttons,
  input  logic [PADS*2-1:0]        types,
  input  logic [PADS-1:0][IW-1:0]  offs,
  input  logic [IW-1:0]            len,
  output logic [3:0]               nib
);

  always_comb begin
    pad_type_t   t;
    logic [11:0] b;
    logic [IW-1:0] k;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    nib = EMPTY_NIB;
    t   = PT_NONE;
    b   = '0;
    k   = '0;
    if (idx < IW'(4)) begin
      case (idx[1:0])
        2'd0:    nib = HDR_NIB0;
        2'd1:    nib = HDR_NIB1;
        2'd2:    nib = HDR_NIB2;
        default: nib = HDR_NIB3;
      endcase
    end else if (idx < IW'(4 + PADS)) begin
      for (int p = 0; p < PADS; p++)
        if (idx == IW'(4 + p)) nib = type_nibble(decode_type(types[2*p +: 2]));
    end else if (idx < len) begin
      // Absent pads have zero length, so their offset window never matches.
      for (int p = 0; p < PADS; p++) begin
        t = decode_type(types[2*p +: 2]);
        if (idx >= offs[p] && idx < offs[p] + IW'(pad_len(t))) begin
          b = buttons[12*p +: 12];
          k = idx - offs[p];
          if (k == IW'(0))
            nib = ~{b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
          else if (k == IW'(1))
            nib = ~{b[BTN_START], b[BTN_A], b[BTN_C], b[BTN_B]};
          else
            nib = ~{b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
        end
      end
    end
  end

endmodule

// File: rtl/multitap_tp_n.sv
// Multitap serializer: TH/TR/TL handshake FSM, snapshot, data offsets and timeout.
module multitap_tp_n
  import multitap_pkg::*;
#(
  parameter int PADS        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic               TH_IN,
  input  logic               TR_IN,
  input  logic [PADS*12-1:0] BUTTONS,
  input  logic [PADS*2-1:0]  PAD_TYPE,
  output logic [3:0]         DOUT,
  output logic               TL_OUT,
  output logic               BUSY
);

  localparam int IW = $clog2(4 + 4*PADS + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  logic                th_q, tr_q;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [PADS*12-1:0]  snap_buttons;
  logic [PADS*2-1:0]   snap_types;
  logic [PADS-1:0][IW-1:0] offs_d, offs_q;
  logic [IW-1:0]       len_d, len_q;
  logic [IW-1:0]       idx_inc;
  logic [CW-1:0]       cnt_inc;
  logic [3:0]          nib_next;
  logic                th_rise, th_fall, tr_edge;

  assign th_rise = TH_IN & ~th_q;
  assign th_fall = ~TH_IN & th_q;
  assign tr_edge = TR_IN ^ tr_q;
  assign idx_inc = (idx == len_q) ? idx : idx + IW'(1);
  assign cnt_inc = cnt + CW'(1);

  // Prefix sums of per-pad lengths give each pad's first data index.
  always_comb begin
    logic [IW-1:0] acc;
    // NOTE: blocking assignments here build a running sum; clocked state uses <= only.
    acc = IW'(4 + PADS);
    for (int p = 0; p < PADS; p++) begin
      offs_d[p] = acc;
      acc = acc + IW'(pad_len(decode_type(snap_types[2*p +: 2])));
    end
    len_d = acc;
  end

  tp_nibble_mux #(.PADS(PADS), .IW(IW)) u_mux (
    .idx     (idx_inc),
    .buttons (snap_buttons),
    .types   (snap_types),
    .offs    (offs_q),
    .len     (len_q),
    .nib     (nib_next)
  );

  // th_q resets low so a TH already low at release is not seen as a falling edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: the snapshot and offset registers are plain flops, so they take a reset value too.
      state        <= ST_IDLE;
      th_q         <= 1'b0;
      tr_q         <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      snap_buttons <= '0;
      snap_types   <= '0;
      offs_q       <= '0;
      len_q        <= '0;
      DOUT         <= IDLE_NIB;
      TL_OUT       <= 1'b1;
      BUSY         <= 1'b0;
    end else if (CE) begin
      th_q   <= TH_IN;
      tr_q   <= TR_IN;
      offs_q <= offs_d;
      len_q  <= len_d;
      if (th_rise) begin
        state  <= ST_IDLE;
        DOUT   <= IDLE_NIB;
        TL_OUT <= 1'b1;
        BUSY   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (th_fall) begin
            state        <= ST_SEQ;
            snap_buttons <= BUTTONS;
            snap_types   <= PAD_TYPE;
            idx          <= '0;
            cnt          <= '0;
            DOUT         <= HDR_NIB0;
            TL_OUT       <= TR_IN;
            BUSY         <= 1'b1;
          end
          ST_SEQ: begin
            if (tr_edge) begin
              idx    <= idx_inc;
              cnt    <= '0;
              DOUT   <= nib_next;
              TL_OUT <= TR_IN;
            end else if (cnt_inc == CW'(TIMEOUT_CYC)) begin
              state  <= ST_ABORT;
              DOUT   <= EMPTY_NIB;
              TL_OUT <= 1'b1;
              BUSY   <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multitap_tp_n.sv
// Directed bench for multitap_tp_n: 4-pad instance at full CE and 1-pad instance at 1/3 CE.
module tb_multitap_tp_n;
  import multitap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce1, th1, tr1;
  logic [47:0] btn1;
  logic [7:0]  typ1;
  logic [3:0]  dout1;
  logic        tl1, busy1;
  logic        ce2, th2, tr2;
  logic [11:0] btn2;
  logic [1:0]  typ2;
  logic [3:0]  dout2;
  logic        tl2, busy2;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp1 [15];
  logic [3:0] exp2 [15];
  logic [3:0] exp6 [9];

  multitap_tp_n #(.PADS(4), .TIMEOUT_CYC(20)) dut1 (
    .CLK(clk), .RESET(rst), .CE(ce1), .TH_IN(th1), .TR_IN(tr1),
    .BUTTONS(btn1), .PAD_TYPE(typ1), .DOUT(dout1), .TL_OUT(tl1), .BUSY(busy1)
  );

  multitap_tp_n #(.PADS(1), .TIMEOUT_CYC(1024)) dut2 (
    .CLK(clk), .RESET(rst), .CE(ce2), .TH_IN(th2), .TR_IN(tr2),
    .BUTTONS(btn2), .PAD_TYPE(typ2), .DOUT(dout2), .TL_OUT(tl2), .BUSY(busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tog1(input string tag, input logic [3:0] exp);
    tr1 = ~tr1;
    cyc();
    check(tag, dout1, exp);
    check({tag, "_tl"}, {3'b0, tl1}, {3'b0, tr1});
  endtask

  task automatic start1(input string tag);
    th1 = 1'b1;
    cyc();
    check({tag, "_idle"}, dout1, 4'h3);
    th1 = 1'b0;
    cyc();
    check({tag, "_n0"}, dout1, 4'h3);
    check({tag, "_busy"}, {3'b0, busy1}, 4'h1);
    check({tag, "_tl0"}, {3'b0, tl1}, {3'b0, tr1});
  endtask

  initial begin
    exp1 = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h0,
             4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    exp2 = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h0,
             4'hF, 4'hF, 4'hE, 4'hB, 4'hF, 4'hF, 4'h7};
    exp6 = '{4'h3, 4'hF, 4'h0, 4'h0, 4'h1, 4'hA, 4'hE, 4'hB, 4'hF};

    rst = 1'b1;
    ce1 = 1'b1; th1 = 1'b1; tr1 = 1'b0;
    btn1 = '0; typ1 = {2'b00, 2'b10, 2'b01, 2'b00};
    ce2 = 1'b0; th2 = 1'b1; tr2 = 1'b0;
    btn2 = 12'h225; typ2 = 2'b01;
    cyc();
    check("rst_dout", dout1, 4'h3);
    check("rst_tl", {3'b0, tl1}, 4'h1);
    check("rst_busy", {3'b0, busy1}, 4'h0);
    check("rst_dout2", dout2, 4'h3);
    rst = 1'b0;
    cyc();

    // 1: all released, full walk plus saturation
    start1("t1");
    for (int i = 1; i < 15; i++) begin
      tog1($sformatf("t1_n%0d", i), exp1[i]);
      check($sformatf("t1_busy%0d", i), {3'b0, busy1}, 4'h1);
    end
    tog1("t1_past_end", 4'hF);
    tog1("t1_saturate", 4'hF);
    check("t1_busy_end", {3'b0, busy1}, 4'h1);

    // 2+3: presses captured at TH fall, then live buttons change mid-sequence
    btn1 = '0;
    btn1[12*1 + BTN_UP]    = 1'b1;
    btn1[12*1 + BTN_A]     = 1'b1;
    btn1[12*3 + BTN_START] = 1'b1;
    start1("t2");
    btn1 = '0;
    btn1[12*0 + BTN_DOWN] = 1'b1;
    for (int i = 1; i < 15; i++)
      tog1($sformatf("t2_n%0d", i), exp2[i]);
    start1("t3");
    for (int i = 1; i < 15; i++)
      tog1($sformatf("t3_n%0d", i), (i == 8) ? 4'hD : exp1[i]);

    // 4: timeout after 20 idle CE ticks, TR ignored in abort
    start1("t4");
    tog1("t4_n1", 4'hF);
    tog1("t4_n2", 4'h0);
    repeat (19) cyc();
    check("t4_busy_before", {3'b0, busy1}, 4'h1);
    check("t4_dout_before", dout1, 4'h0);
    cyc();
    check("t4_abort_dout", dout1, 4'hF);
    check("t4_abort_tl", {3'b0, tl1}, 4'h1);
    check("t4_abort_busy", {3'b0, busy1}, 4'h0);
    tr1 = ~tr1;
    cyc();
    check("t4_abort_tr", dout1, 4'hF);
    check("t4_abort_tl2", {3'b0, tl1}, 4'h1);
    th1 = 1'b1;
    cyc();
    check("t4_rise", dout1, 4'h3);

    // 5: async reset mid-sequence with TH held low
    start1("t5");
    for (int i = 1; i < 6; i++)
      tog1($sformatf("t5_n%0d", i), exp1[i]);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_dout", dout1, 4'h3);
    check("t5_rst_tl", {3'b0, tl1}, 4'h1);
    check("t5_rst_busy", {3'b0, busy1}, 4'h0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tr1 = ~tr1;
      cyc();
      check($sformatf("t5_hold%0d", i), dout1, 4'h3);
      check($sformatf("t5_hold_busy%0d", i), {3'b0, busy1}, 4'h0);
    end
    start1("t5b");
    tog1("t5b_n1", 4'hF);

    // 6: PADS=1, 6-button pad, CE at one tick in three
    ce2 = 1'b1;
    cyc();
    ce2 = 1'b0;
    th2 = 1'b0;
    cyc();
    check("t6_fall_noce", {3'b0, busy2}, 4'h0);
    ce2 = 1'b1;
    cyc();
    ce2 = 1'b0;
    check("t6_n0", dout2, exp6[0]);
    check("t6_busy", {3'b0, busy2}, 4'h1);
    for (int i = 1; i < 9; i++) begin
      tr2 = ~tr2;
      cyc();
      check($sformatf("t6_hold%0d", i), dout2, exp6[i-1]);
      cyc();
      ce2 = 1'b1;
      cyc();
      ce2 = 1'b0;
      check($sformatf("t6_n%0d", i), dout2, exp6[i]);
      check($sformatf("t6_tl%0d", i), {3'b0, tl2}, {3'b0, tr2});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
